// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one synchronous sprite ROM between N_REQ sprite
// address generators. Grants one requester per cycle in round-robin order,
// drives the shared ROM address, and tags the returned palette index with a
// one-hot valid so each pipeline can pick up its own pixel.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0] N_REQ_EXT = (PTR_W+1)'(N_REQ);

  logic [PTR_W-1:0]     ptr;
  logic [N_REQ-1:0]     eligible;
  logic [2*N_REQ-1:0]   elig_dbl;
  logic [N_REQ-1:0]     elig_rot;
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_off;
  logic [PTR_W:0]       pick_sum;
  logic [PTR_W:0]       pick_idx_ext;
  logic [PTR_W:0]       next_ptr_ext;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic [N_REQ-1:0]     gnt_nxt;
  logic [ADDR_W-1:0]    sel_addr;
  logic [N_REQ-1:0]     tag_pipe [ROM_LAT];
  logic                 pipe_busy;

  // The line granted this cycle is masked so a request held one extra
  // cycle (while the requester reacts to gnt) is not granted twice.
  assign eligible = req & ~gnt & {N_REQ{en}};

  // Rotate the eligible set so bit 0 corresponds to the current pointer.
  assign elig_dbl = {eligible, eligible} >> ptr;
  assign elig_rot = elig_dbl[N_REQ-1:0];

  // Find the lowest set bit of the rotated vector (distance from ptr).
  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        pick_valid = 1'b1;
        pick_off   = PTR_W'(i);
      end
    end
  end

  // Convert the distance back to an absolute requester index and the
  // pointer that follows it, both wrapping modulo N_REQ.
  always_comb begin
    pick_sum     = {1'b0, ptr} + {1'b0, pick_off};
    pick_idx_ext = (pick_sum >= N_REQ_EXT) ? (pick_sum - N_REQ_EXT) : pick_sum;
    next_ptr_ext = pick_idx_ext + (PTR_W+1)'(1);
    if (next_ptr_ext == N_REQ_EXT) begin
      next_ptr_ext = '0;
    end
    pick_idx = pick_idx_ext[PTR_W-1:0];
    next_ptr = next_ptr_ext[PTR_W-1:0];
  end

  // One-hot grant and address mux for the chosen requester.
  always_comb begin
    gnt_nxt  = '0;
    sel_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_valid && (pick_idx == PTR_W'(k))) begin
        gnt_nxt[k] = 1'b1;
        sel_addr   = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Arbitration state: grant pulse, shared ROM address and round-robin pointer.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= '0;
      rom_addr <= '0;
      ptr      <= '0;
    end else begin
      gnt <= gnt_nxt;
      if (pick_valid) begin
        rom_addr <= sel_addr;
        ptr      <= next_ptr;
      end
    end
  end

  // Return path: carry the grant tag alongside the ROM latency, then
  // capture rom_q for the tagged requester.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      tag_pipe[0] <= gnt;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      rd_valid <= tag_pipe[ROM_LAT-1];
      if (|tag_pipe[ROM_LAT-1]) begin
        rd_data <= rom_q;
      end
    end
  end

  // Any tag still travelling through the return pipeline counts as in flight.
  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < ROM_LAT; s++) begin
      pipe_busy = pipe_busy | (|tag_pipe[s]);
    end
  end

  assign busy = pipe_busy | (|gnt);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter with a ROM model returning
// q = addr[3:0] one cycle after the address is sampled.
module tb_sprite_rom_arbiter;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 4;
  localparam int ROM_LAT = 1;

  logic                    vga_clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    en = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_q = '0;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .en      (en),
    .req     (req),
    .req_addr(req_addr),
    .gnt     (gnt),
    .rom_addr(rom_addr),
    .rom_q   (rom_q),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Pixel clock.
  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM model with one cycle latency: content is the low nibble of the address.
  always @(posedge vga_clk) rom_q <= rom_addr[3:0];

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic e);
    req = r;
    en  = e;
  endtask

  task automatic setAddr(input int k, input logic [ADDR_W-1:0] a);
    req_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b1);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [3:0] exp_g;
  logic [3:0] exp_v;
  logic [3:0] prev_g;
  logic [3:0] rr_q [4];
  int pulses;

  initial begin
    rr_q[0] = 4'h1;
    rr_q[1] = 4'h7;
    rr_q[2] = 4'hC;
    rr_q[3] = 4'h5;

    // Reset then idle.
    $display("[TB] reset and idle");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_gnt", gnt, 4'b0000);
    checkOutput("rst_rd_valid", rd_valid, 4'b0000);
    checkOutput("rst_rd_data", rd_data, 4'h0);
    checkOutput("rst_busy", busy, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_gnt", gnt, 4'b0000);
      checkOutput("idle_rd_valid", rd_valid, 4'b0000);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_rom_addr", rom_addr, 13'd0);
    end

    // Single request from requester 2 at address 1234 (low nibble 2).
    $display("[TB] single request");
    setAddr(2, 13'd1234);
    applyStimulus(4'b0100, 1'b1);
    tick();
    checkOutput("single_gnt", gnt, 4'b0100);
    checkOutput("single_rom_addr", rom_addr, 13'd1234);
    checkOutput("single_busy_gnt", busy, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("single_gnt_off", gnt, 4'b0000);
    checkOutput("single_busy_pipe", busy, 1'b1);
    checkOutput("single_no_early_valid", rd_valid, 4'b0000);
    tick();
    checkOutput("single_rd_valid", rd_valid, 4'b0100);
    checkOutput("single_rd_data", rd_data, 4'h2);
    checkOutput("single_busy_done", busy, 1'b0);
    tick();
    checkOutput("single_rd_valid_off", rd_valid, 4'b0000);
    checkOutput("single_rd_data_hold", rd_data, 4'h2);

    // Round-robin with all requesters held.
    $display("[TB] round robin");
    doReset();
    setAddr(0, 13'h0A1);
    setAddr(1, 13'h0B7);
    setAddr(2, 13'h0CC);
    setAddr(3, 13'h0D5);
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_g = (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000;
      checkOutput("rr_gnt", gnt, exp_g);
      if (i >= 2) begin
        exp_v = 4'b0001 << ((i - 2) % 4);
        checkOutput("rr_rd_valid", rd_valid, exp_v);
        checkOutput("rr_rd_data", rd_data, rr_q[(i - 2) % 4]);
      end
      if (i == 7) applyStimulus(4'b0000, 1'b1);
    end

    // Held request masking on a single line.
    $display("[TB] held request masking");
    doReset();
    setAddr(1, 13'h123);
    applyStimulus(4'b0010, 1'b1);
    pulses = 0;
    prev_g = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      checkOutput("hold_gnt", gnt, exp_g);
      checkOutput("hold_no_back_to_back", prev_g & gnt, 4'b0000);
      if (gnt != 4'b0000) pulses++;
      prev_g = gnt;
    end
    checkOutput("hold_pulse_count", pulses, 3);
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    tick();

    // en gating: in-flight read completes, pointer frozen.
    $display("[TB] enable gating");
    doReset();
    setAddr(0, 13'h1E3);
    setAddr(1, 13'h0F0);
    applyStimulus(4'b0011, 1'b1);
    tick();
    checkOutput("en_first_gnt", gnt, 4'b0001);
    applyStimulus(4'b0011, 1'b0);
    tick();
    checkOutput("en_low_gnt_a", gnt, 4'b0000);
    tick();
    checkOutput("en_low_gnt_b", gnt, 4'b0000);
    checkOutput("en_inflight_valid", rd_valid, 4'b0001);
    checkOutput("en_inflight_data", rd_data, 4'h3);
    tick();
    checkOutput("en_low_gnt_c", gnt, 4'b0000);
    checkOutput("en_low_busy", busy, 1'b0);
    checkOutput("en_low_rd_valid", rd_valid, 4'b0000);
    tick();
    checkOutput("en_low_gnt_d", gnt, 4'b0000);
    applyStimulus(4'b0011, 1'b1);
    tick();
    checkOutput("en_resume_gnt", gnt, 4'b0010);
    checkOutput("en_resume_addr", rom_addr, 13'h0F0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    tick();

    // Reset mid-flight discards the in-flight read.
    $display("[TB] reset mid-flight");
    doReset();
    setAddr(3, 13'h1F9);
    setAddr(0, 13'h004);
    applyStimulus(4'b1000, 1'b1);
    tick();
    checkOutput("midrst_gnt3", gnt, 4'b1000);
    applyStimulus(4'b0000, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy_cleared", busy, 1'b0);
    checkOutput("midrst_gnt_cleared", gnt, 4'b0000);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("midrst_no_valid", rd_valid, 4'b0000);
      checkOutput("midrst_rd_data", rd_data, 4'h0);
    end
    applyStimulus(4'b1001, 1'b1);
    tick();
    checkOutput("midrst_next_gnt", gnt, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    tick();

    // Pointer returns to 0 after reset even when it was advanced.
    $display("[TB] pointer reset");
    setAddr(1, 13'h0AA);
    applyStimulus(4'b0010, 1'b1);
    tick();
    checkOutput("ptr_pre_gnt", gnt, 4'b0010);
    applyStimulus(4'b0000, 1'b1);
    tick();
    doReset();
    setAddr(2, 13'h0BB);
    applyStimulus(4'b0101, 1'b1);
    tick();
    checkOutput("ptr_after_reset_gnt", gnt, 4'b0001);
    tick();
    checkOutput("ptr_after_reset_gnt2", gnt, 4'b0100);
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (one index per pixel, palette-indexed output) between N_REQ sprite pipelines, e.g. several enemy sprite mappers.
- Each pipeline submits a ROM address with a request. The arbiter grants one requester per cycle in round-robin order and drives the shared ROM address.
- It returns the ROM data to the granted requester with a one-hot valid tag.
- It sits between the per-sprite address generators and the single ROM/palette pair.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 13, ROM address width.
- DATA_W, 4, ROM data (palette index) width.
- ROM_LAT, 1, ROM read latency in cycles from address sampled to q valid (1..3).

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  when low, no new grants issue; in-flight reads still complete.
- req  in  N_REQ  per-requester request, level.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice k = requester k; must be stable while req[k]=1.
- gnt  out  N_REQ  one-hot grant pulse, registered.
- rom_addr  out  ADDR_W  address to shared ROM, registered.
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after the ROM samples rom_addr.
- rd_valid  out  N_REQ  one-hot, marks rd_data as belonging to requester k.
- rd_data  out  DATA_W  registered copy of rom_q.
- busy  out  1  high while any read is in flight in the return pipeline.

Behaviour:
- Reset (async assert, sync release): gnt=0, rom_addr=0, rd_valid=0, rd_data=0, busy=0, round-robin pointer=0, return-tag pipeline cleared.
- Eligible set at edge E: req[k]=1 AND gnt[k]=0 (the requester granted in the current cycle is masked, so a request held one extra cycle is not granted twice) AND en=1.
- Arbitration at edge E:
  - Pick the first eligible k searching ptr, ptr+1, ..., wrapping mod N_REQ.
  - Register gnt = onehot(k) and rom_addr = req_addr[k]; ptr <= (k+1) mod N_REQ.
  - If none eligible: gnt <= 0, rom_addr holds, ptr holds.
- gnt is high exactly one cycle per grant. A requester may keep req high to request again; it then wins at most every other cycle.
- Return path: tag pipeline of depth ROM_LAT+1 carries onehot(k). At edge E+ROM_LAT+1: rd_valid <= tag, rd_data <= rom_q. With ROM_LAT=1, rd_valid is asserted 2 cycles after gnt.
- rd_data is updated only when the tag is non-zero; otherwise it holds. rd_valid returns to 0 when the tag is 0.
- Throughput: one grant per cycle sustained across different requesters. Grants are never dropped, and returns keep issue order.
- busy = OR of all tag pipeline stages and gnt.
- en low: current grant and in-flight reads complete normally; ptr frozen. When en rises, arbitration resumes from the frozen ptr.
- Single requester holding req with N_REQ=1: grants every other cycle.
- Simultaneous req and new request on a masked line: masked for that cycle only, and eligible at the next edge.
- Reset mid-operation: all in-flight reads are discarded, with no rd_valid after reset deasserts. ptr returns to 0.
- Width rule: req_addr slice k = bits [(k+1)*ADDR_W-1 : k*ADDR_W]. No arithmetic on addresses; passed through unchanged.

Test Plan:
- Reset then idle: req=0 for 10 cycles -> gnt=0, rd_valid=0, busy=0, rom_addr=0 throughout.
- Single request: req=4'b0100 with addr2=13'd1234, dropped on gnt. Expect gnt=4'b0100 one cycle after the sampling edge, rom_addr=1234. Two cycles later rd_valid=4'b0100 and rd_data equals ROM content at 1234 (ROM model q=addr[3:0] -> 4'h2).
- Round-robin fairness: req=4'b1111 held continuously (re-asserted after each grant) -> grant order 0,1,2,3,0,1... Each requester is granted once per 4 grants, and rd_valid follows the same order, 2 cycles delayed.
- Held request masking: only req[1] high for 6 cycles -> gnt[1] pulses on alternate cycles (3 pulses), and there are never two consecutive gnt cycles.
- en gating: req=4'b0011 with en dropped after the first grant to 0 -> the in-flight read still returns rd_valid=4'b0001. No gnt while en=0. After en rises, the next grant goes to requester 1.
- Reset mid-flight: assert reset_n=0 one cycle after gnt=4'b1000 -> rd_valid stays 0 after release. The next grant with req=4'b1001 goes to requester 0 (ptr=0).
